// File: rtl/zuc_lfsr_ctrl.sv
// ZUC LFSR/R1/R2 controller: key/IV load, init rounds, keystream handshake around an external F.
// Optional `ZUC_KS_LEN_EN adds ks_len/done for bounded-length sessions.
module zuc_lfsr_ctrl #(
  parameter int INIT_ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  output logic [31:0]  x0,
  output logic [31:0]  x1,
  output logic [31:0]  x2,
  output logic [31:0]  r1,
  output logic [31:0]  r2,
  input  logic [31:0]  w,
  input  logic [31:0]  r1_next,
  input  logic [31:0]  r2_next,
  output logic [31:0]  ks_data,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic         busy
`ifdef ZUC_KS_LEN_EN
  ,
  input  logic [31:0]  ks_len,
  output logic         done
`endif
);

  typedef enum logic [1:0] {IDLE, INIT, DISCARD, KS} state_t;

  localparam logic [5:0] LAST_ROUND = 6'(INIT_ROUNDS - 1);
  localparam logic [239:0] D_CONST = {
    15'h44D7, 15'h26BC, 15'h626B, 15'h135E, 15'h5789, 15'h35E2, 15'h7135, 15'h09AF,
    15'h4D78, 15'h2F13, 15'h6BC4, 15'h1AF1, 15'h5E26, 15'h3C4D, 15'h789A, 15'h47AC
  };

  state_t            state_reg, state_next;
  logic [15:0][30:0] s_reg;
  logic [15:0][30:0] s_load;
  logic [15:0][30:0] s_shift;
  logic [31:0]       r1_reg, r2_reg;
  logic [5:0]        cnt_reg;
  logic              do_round;
  logic              init_mode;
  logic [30:0]       v;
  logic [30:0]       s16_raw;
  logic [30:0]       s16;
  logic [31:0]       x3;

  // Addition modulo 2^31-1 with end-around carry; only 0+0 yields 0.
  function automatic logic [30:0] add31(input logic [30:0] a, input logic [30:0] b);
    logic [31:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[30:0] + {30'd0, sum[31]};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_load
      assign s_load[gi] = {key[127-8*gi -: 8], D_CONST[239-15*gi -: 15], iv[127-8*gi -: 8]};
    end
    for (gi = 0; gi < 15; gi++) begin : g_shift
      assign s_shift[gi] = s_reg[gi+1];
    end
  endgenerate
  assign s_shift[15] = s16;

  // Multiplications by 2^k are 31-bit left rotations.
  assign v = add31(add31(add31(add31(add31(
               {s_reg[15][15:0], s_reg[15][30:16]},
               {s_reg[13][13:0], s_reg[13][30:14]}),
               {s_reg[10][9:0],  s_reg[10][30:10]}),
               {s_reg[4][10:0],  s_reg[4][30:11]}),
               {s_reg[0][22:0],  s_reg[0][30:23]}),
               s_reg[0]);

  assign s16_raw = init_mode ? add31(v, w[31:1]) : v;
  assign s16     = (s16_raw == 31'd0) ? 31'h7FFF_FFFF : s16_raw;

  assign x0 = {s_reg[15][30:15], s_reg[14][15:0]};
  assign x1 = {s_reg[11][15:0],  s_reg[9][30:15]};
  assign x2 = {s_reg[7][15:0],   s_reg[5][30:15]};
  assign x3 = {s_reg[2][15:0],   s_reg[0][30:15]};
  assign r1 = r1_reg;
  assign r2 = r2_reg;

  assign ks_valid = (state_reg == KS);
  assign ks_data  = ks_valid ? (w ^ x3) : 32'd0;
  assign busy     = (state_reg == INIT) || (state_reg == DISCARD);

`ifdef ZUC_KS_LEN_EN
  logic [31:0] len_reg;
  logic        done_reg;
  logic        done_set;
  assign done = done_reg;
`endif

  always_comb begin
    state_next = state_reg;
    do_round   = 1'b0;
    init_mode  = 1'b0;
`ifdef ZUC_KS_LEN_EN
    done_set   = 1'b0;
`endif
    case (state_reg)
      IDLE: ;
      INIT: begin
        do_round  = 1'b1;
        init_mode = 1'b1;
        if (cnt_reg == LAST_ROUND) state_next = DISCARD;
      end
      DISCARD: begin
        do_round   = 1'b1;
        state_next = KS;
`ifdef ZUC_KS_LEN_EN
        if (len_reg == 32'd0) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
`endif
      end
      KS: begin
        if (ks_ready) begin
          do_round = 1'b1;
`ifdef ZUC_KS_LEN_EN
          if (len_reg == 32'd1) begin
            state_next = IDLE;
            done_set   = 1'b1;
          end
`endif
        end
      end
      default: state_next = IDLE;
    endcase
    // A new start always wins, aborting whatever session is running.
    if (start) begin
      state_next = INIT;
      do_round   = 1'b0;
      init_mode  = 1'b0;
`ifdef ZUC_KS_LEN_EN
      done_set   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_reg   <= '0;
      r1_reg  <= 32'd0;
      r2_reg  <= 32'd0;
      cnt_reg <= 6'd0;
    end else if (start) begin
      s_reg   <= s_load;
      r1_reg  <= 32'd0;
      r2_reg  <= 32'd0;
      cnt_reg <= 6'd0;
    end else if (do_round) begin
      s_reg  <= s_shift;
      r1_reg <= r1_next;
      r2_reg <= r2_next;
      if (init_mode && (cnt_reg != LAST_ROUND)) cnt_reg <= cnt_reg + 6'd1;
    end
  end

`ifdef ZUC_KS_LEN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_reg  <= 32'd0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= done_set;
      if (start) len_reg <= ks_len;
      else if ((state_reg == KS) && ks_ready) len_reg <= len_reg - 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_zuc_lfsr_ctrl.sv
// Bench for zuc_lfsr_ctrl: a stand-in F function, an arithmetic LFSR model feeding a
// keystream scoreboard, plus hand-computed load/reset/zero-feedback checks.
module tb_zuc_lfsr_ctrl;

  localparam longint unsigned P = 64'h7FFF_FFFF;
  localparam logic [14:0] DC [16] = '{
    15'h44D7, 15'h26BC, 15'h626B, 15'h135E, 15'h5789, 15'h35E2, 15'h7135, 15'h09AF,
    15'h4D78, 15'h2F13, 15'h6BC4, 15'h1AF1, 15'h5E26, 15'h3C4D, 15'h789A, 15'h47AC
  };
  localparam logic [127:0] ALL1 = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n, start, ks_ready;
  logic [127:0] key, iv;
  logic [31:0]  x0, x1, x2, r1, r2, w, r1_next, r2_next, ks_data;
  logic         ks_valid, busy;
  logic [95:0]  fo;
  logic [31:0]  ks_len;
`ifdef ZUC_KS_LEN_EN
  logic         done;
`endif

  always #5 clk = ~clk;

  zuc_lfsr_ctrl #(.INIT_ROUNDS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .iv(iv),
    .x0(x0), .x1(x1), .x2(x2), .r1(r1), .r2(r2),
    .w(w), .r1_next(r1_next), .r2_next(r2_next),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy)
`ifdef ZUC_KS_LEN_EN
    , .ks_len(ks_len), .done(done)
`endif
  );

  // Stand-in nonlinear F: any deterministic function exercises the controller.
  function automatic logic [95:0] f_fn(input logic [31:0] a0, a1, a2, q1, q2);
    logic [31:0] wv, t, u;
    wv = (a0 ^ q1) + q2;
    t  = q1 + a1;
    u  = q2 ^ a2;
    return {wv, {t[20:0], t[31:21]} ^ u, {u[7:0], u[31:8]} + t};
  endfunction

  always_comb fo = f_fn(x0, x1, x2, r1, r2);
  assign w       = fo[95:64];
  assign r1_next = fo[63:32];
  assign r2_next = fo[31:0];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  bit          sb_en = 1'b0;
  bit          hold_v = 1'b0;
  logic [31:0] hold_d;
  int          word_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain modular arithmetic on 64-bit integers.
  logic [30:0] ms [16];
  logic [31:0] mr1, mr2;

  task automatic m_step(input bit init, output logic [31:0] z);
    logic [31:0]     a0, a1, a2, a3;
    logic [95:0]     f;
    longint unsigned acc;
    a0  = {ms[15][30:15], ms[14][15:0]};
    a1  = {ms[11][15:0],  ms[9][30:15]};
    a2  = {ms[7][15:0],   ms[5][30:15]};
    a3  = {ms[2][15:0],   ms[0][30:15]};
    f   = f_fn(a0, a1, a2, mr1, mr2);
    z   = f[95:64] ^ a3;
    acc = (64'(ms[15]) << 15) + (64'(ms[13]) << 17) + (64'(ms[10]) << 21)
        + (64'(ms[4]) << 20) + 64'(ms[0]) * 257;
    acc = acc % P;
    if (init) acc = (acc + 64'(f[95:65])) % P;
    if (acc == 0) acc = P;
    for (int i = 0; i < 15; i++) ms[i] = ms[i+1];
    ms[15] = acc[30:0];
    mr1 = f[63:32];
    mr2 = f[31:0];
  endtask

  task automatic m_session(input logic [127:0] k, input logic [127:0] v, input int n);
    logic [31:0] z;
    for (int i = 0; i < 16; i++) ms[i] = {k[127-8*i -: 8], DC[i], v[127-8*i -: 8]};
    mr1 = 32'd0;
    mr2 = 32'd0;
    for (int i = 0; i < 32; i++) m_step(1'b1, z);
    m_step(1'b0, z);
    for (int i = 0; i < n; i++) begin
      m_step(1'b0, z);
      exp_q.push_back(z);
    end
  endtask

  // Monitor: one line per accepted word, plus hold-stability while stalled.
  always @(negedge clk) begin
    if (sb_en) begin
      if (hold_v && ks_valid) begin
        checks++;
        if (ks_data !== hold_d) begin
          errors++;
          $display("FAIL ks_data_hold: got %h expected %h", ks_data, hold_d);
        end
      end
      hold_v = ks_valid && !ks_ready;
      hold_d = ks_data;
      if (ks_valid && ks_ready) begin
        checks++;
        word_n++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h expected none", ks_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (ks_data !== e) begin
            errors++;
            $display("FAIL keystream_word %0d: got %h expected %h", word_n, ks_data, e);
          end else begin
            $display("word %0d: ks_data=%h ok", word_n, ks_data);
          end
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic do_start(input logic [127:0] k, input logic [127:0] v);
    start = 1'b1;
    key   = k;
    iv    = v;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (ks_valid) break;
    end
  endtask

  task automatic drain(input bit random_ready);
    int budget;
    budget = 500;
    while (exp_q.size() > 0 && budget > 0) begin
      ks_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      budget--;
    end
    ks_ready = 1'b0;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x0"}, x0, 32'd0);
    chk({tag, "_x1"}, x1, 32'd0);
    chk({tag, "_x2"}, x2, 32'd0);
    chk({tag, "_r1"}, r1, 32'd0);
    chk({tag, "_r2"}, r2, 32'd0);
    chk({tag, "_ks_valid"}, 32'(ks_valid), 32'd0);
    chk({tag, "_ks_data"}, ks_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; key = '0; iv = '0; ks_ready = 1'b0; ks_len = 32'd1000;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    start = 1'b1;                       // ignored while in reset
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Set 1 (all zero), ready held high.
    m_session('0, '0, 6);
    sb_en = 1'b1;
    ks_ready = 1'b1;
    do_start('0, '0);
    chk("load0_x0", x0, 32'h008F9A00);
    chk("load0_x1", x1, 32'hF100005E);
    chk("load0_x2", x2, 32'hAF00006B);
    chk("load0_r1", r1, 32'd0);
    chk("load0_busy", 32'(busy), 32'd1);
    chk("load0_ks_data", ks_data, 32'd0);
    wait_valid(cyc);
    chk("latency_set1", 32'(cyc), 32'd33);
    drain(1'b0);
    chk("ks_busy", 32'(busy), 32'd0);

    // Set 2 (all ones).
    m_session(ALL1, ALL1, 6);
    do_start(ALL1, ALL1);
    chk("load1_x0", x0, 32'hFF8F9AFF);
    chk("load1_x1", x1, 32'hF1FFFF5E);
    chk("load1_x2", x2, 32'hAFFFFF6B);
    wait_valid(cyc);
    chk("latency_set2", 32'(cyc), 32'd33);
    drain(1'b0);

    // Set 1 with random backpressure.
    m_session('0, '0, 10);
    do_start('0, '0);
    wait_valid(cyc);
    drain(1'b1);

    // Abort mid-init with set 2.
    do_start('0, '0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    m_session(ALL1, ALL1, 5);
    do_start(ALL1, ALL1);
    wait_valid(cyc);
    chk("latency_abort", 32'(cyc), 32'd33);
    drain(1'b0);

    // Reset in KS.
    chk("pre_reset_valid", 32'(ks_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("midks_reset");
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("idle_valid", 32'(ks_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Zero feedback: clear the LFSR by backdoor, then one work round.
    sb_en = 1'b0;
    do_start('0, '0);
    wait_valid(cyc);
    dut.s_reg = '0;
    #1;
    chk("backdoor_x0", x0, 32'd0);
    ks_ready = 1'b1;
    @(posedge clk); #1;
    ks_ready = 1'b0;
    chk("zero_feedback_x0", x0, 32'hFFFF0000);

`ifdef ZUC_KS_LEN_EN
    begin
      bit saw_valid;
      ks_len = 32'd3;
      sb_en = 1'b1;
      m_session('0, '0, 3);
      do_start('0, '0);
      wait_valid(cyc);
      drain(1'b0);
      chk("len3_done", 32'(done), 32'd1);
      chk("len3_valid", 32'(ks_valid), 32'd0);
      @(posedge clk); #1;
      chk("len3_done_pulse", 32'(done), 32'd0);
      ks_len = 32'd0;
      do_start('0, '0);
      saw_valid = 1'b0;
      cyc = 0;
      while (cyc < 60) begin
        @(posedge clk); #1;
        cyc++;
        if (ks_valid) saw_valid = 1'b1;
        if (done) break;
      end
      chk("len0_done_cycle", 32'(cyc), 32'd33);
      chk("len0_no_valid", 32'(saw_valid), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
